// File: rtl/mtr_pkg.sv
// Shared types, widths and helpers for the two-channel drive scheduler.
package mtr_pkg;

  localparam int unsigned DUTY_W = 11;
  localparam int unsigned REQ_W  = 12;

  localparam logic [DUTY_W-1:0] SLEW_DEF     = 11'd64;
  localparam logic [DUTY_W-1:0] BRK_SLEW_DEF = 11'd256;

  typedef enum logic [1:0] {IDLE, RUN, BRAKE} mtr_state_t;

  // Unsigned minimum on the widened internal arithmetic width.
  function automatic logic [DUTY_W:0] umin(input logic [DUTY_W:0] a, input logic [DUTY_W:0] b);
    logic [DUTY_W:0] res;
    res = (a < b) ? a : b;
    return res;
  endfunction

  // Signed torque request to magnitude; the most negative code saturates to full scale.
  function automatic logic [DUTY_W-1:0] req_to_mag(input logic [REQ_W-1:0] req);
    logic [REQ_W-1:0]  neg;
    logic [DUTY_W-1:0] res;
    neg = (~req) + REQ_W'(1);
    if (!req[REQ_W-1]) begin
      res = req[DUTY_W-1:0];
    end else if (req[DUTY_W-1:0] == '0) begin
      res = '1;
    end else begin
      res = neg[DUTY_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtr_slew_ch.sv
// One drive channel: request target registers, per-period slew step and
// direction reversal that only happens once the duty has reached zero.
module mtr_slew_ch
  import mtr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  mtr_state_t        mode,
  input  logic [DUTY_W-1:0] step,
  input  logic              load,
  input  logic [REQ_W-1:0]  req,
  output logic [DUTY_W-1:0] duty,
  output logic              dir,
  output logic              at_tgt,
  output logic              zero_nxt
);

  logic [DUTY_W-1:0] duty_q, duty_d, tgt_mag_q, tgt_mag_d;
  logic              dir_q, dir_d, tgt_dir_q, tgt_dir_d;
  logic [DUTY_W:0]   duty_w, tgt_w, step_w, nxt_w;
  logic              unused_nxt_msb;

  // Latest accepted request overwrites the target; it persists otherwise.
  always_comb begin
    tgt_mag_d = tgt_mag_q;
    tgt_dir_d = tgt_dir_q;
    if (load) begin
      tgt_mag_d = req_to_mag(req);
      tgt_dir_d = req[REQ_W-1];
    end
  end

  // Per-period duty/dir step; widened by one bit so differences cannot wrap.
  always_comb begin
    duty_w = {1'b0, duty_q};
    tgt_w  = {1'b0, tgt_mag_q};
    step_w = {1'b0, step};
    nxt_w  = duty_w;
    dir_d  = dir_q;
    if (tick) begin
      case (mode)
        RUN: begin
          if (dir_q == tgt_dir_q) begin
            if (tgt_w >= duty_w) nxt_w = duty_w + umin(step_w, tgt_w - duty_w);
            else                 nxt_w = duty_w - umin(step_w, duty_w - tgt_w);
          end else if (duty_q != '0) begin
            nxt_w = duty_w - umin(step_w, duty_w);
          end else begin
            // Reverse only at zero, and start the new direction on the same tick.
            dir_d = tgt_dir_q;
            nxt_w = umin(step_w, tgt_w);
          end
        end
        BRAKE:   nxt_w = duty_w - umin(step_w, duty_w);
        default: nxt_w = '0;
      endcase
    end
    duty_d = nxt_w[DUTY_W-1:0];
  end

  assign unused_nxt_msb = nxt_w[DUTY_W];

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= '0;
      dir_q     <= 1'b0;
      tgt_mag_q <= '0;
      tgt_dir_q <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      dir_q     <= dir_d;
      tgt_mag_q <= tgt_mag_d;
      tgt_dir_q <= tgt_dir_d;
    end
  end

  assign duty     = duty_q;
  assign dir      = dir_q;
  assign at_tgt   = (duty_q == tgt_mag_q) && (dir_q == tgt_dir_q);
  assign zero_nxt = (duty_d == '0);

endmodule

// File: rtl/mtr_drive_sched.sv
// Two-channel drive scheduler: period counter aligned with the PWM11
// instances, IDLE/RUN/BRAKE sequencing, request handshake and busy flag.
module mtr_drive_sched
  import mtr_pkg::*;
#(
  parameter logic [DUTY_W-1:0] SLEW     = SLEW_DEF,
  parameter logic [DUTY_W-1:0] BRK_SLEW = BRK_SLEW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [REQ_W-1:0]  lft_req,
  input  logic [REQ_W-1:0]  rght_req,
  output logic [DUTY_W-1:0] lft_duty,
  output logic [DUTY_W-1:0] rght_duty,
  output logic              lft_dir,
  output logic              rght_dir,
  output logic              prd_strt,
  output logic              busy
);

  mtr_state_t        state_q, state_d, ch_mode;
  logic [DUTY_W-1:0] cnt_q, cnt_d, ch_step;
  logic              prd_strt_q, prd_strt_d;
  logic              tick, accept;
  logic              lft_at, rght_at, lft_zero, rght_zero;

  // Free-running period counter; wraps at 2047 like the PWM11 counters.
  always_comb begin
    cnt_d      = cnt_q + DUTY_W'(1);
    tick       = (cnt_q == '1);
    prd_strt_d = tick;
  end

  // Counter and period-start pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      prd_strt_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      prd_strt_q <= prd_strt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; en is only sampled on tick once running, and BRAKE always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (tick && !en) state_d = BRAKE;
      BRAKE:   if (tick && lft_zero && rght_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the first brake step lands on the same tick that sees en low.
  always_comb begin
    ch_mode = state_q;
    if (state_q == RUN && !en) ch_mode = BRAKE;
    ch_step = (ch_mode == BRAKE) ? BRK_SLEW : SLEW;
    req_rdy = (state_q != BRAKE);
    accept  = req_vld && req_rdy;
    // A channel sitting on its target in RUN is settled, so only motion or braking counts.
    busy    = (state_q == BRAKE) || !lft_at || !rght_at;
  end

  mtr_slew_ch u_lft (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .mode     (ch_mode),
    .step     (ch_step),
    .load     (accept),
    .req      (lft_req),
    .duty     (lft_duty),
    .dir      (lft_dir),
    .at_tgt   (lft_at),
    .zero_nxt (lft_zero)
  );

  mtr_slew_ch u_rght (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .mode     (ch_mode),
    .step     (ch_step),
    .load     (accept),
    .req      (rght_req),
    .duty     (rght_duty),
    .dir      (rght_dir),
    .at_tgt   (rght_at),
    .zero_nxt (rght_zero)
  );

  assign prd_strt = prd_strt_q;

endmodule

// File: tb/tb_mtr_drive_sched.sv
// Directed bench for mtr_drive_sched with default SLEW=64 / BRK_SLEW=256.
module tb_mtr_drive_sched;

  logic        clk = 1'b0;
  logic        rst_n, en, req_vld, req_rdy;
  logic [11:0] lft_req, rght_req;
  logic [10:0] lft_duty, rght_duty;
  logic        lft_dir, rght_dir, prd_strt, busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  int   last_pulse = 0;
  logic pulse = 1'b0;
  logic early;

  always #5 clk = ~clk;

  mtr_drive_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .lft_req   (lft_req),
    .rght_req  (rght_req),
    .lft_duty  (lft_duty),
    .rght_duty (rght_duty),
    .lft_dir   (lft_dir),
    .rght_dir  (rght_dir),
    .prd_strt  (prd_strt),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, sampled 1 time unit later; checks spacing of period pulses.
  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
    pulse = prd_strt;
    if (prd_strt === 1'b1) begin
      chk("prd_gap", edge_cnt - last_pulse, 2048);
      last_pulse = edge_cnt;
    end
  endtask

  task automatic next_period();
    pulse = 1'b0;
    for (int i = 0; i < 2100 && !pulse; i++) step();
    chk("period_reached", {31'd0, pulse}, 1);
  endtask

  task automatic send(input logic [11:0] l, input logic [11:0] r);
    lft_req  = l;
    rght_req = r;
    req_vld  = 1'b1;
    step();
    req_vld  = 1'b0;
  endtask

  task automatic tick_chk(input int k, input int le, input int ld, input int re, input int rd);
    next_period();
    chk($sformatf("t%0d_lft_duty", k), lft_duty, le);
    chk($sformatf("t%0d_lft_dir", k), lft_dir, ld);
    chk($sformatf("t%0d_rght_duty", k), rght_duty, re);
    chk($sformatf("t%0d_rght_dir", k), rght_dir, rd);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req_vld = 1'b0; lft_req = '0; rght_req = '0;
    #12;
    chk("rst_lft_duty", lft_duty, 0);
    chk("rst_rght_duty", rght_duty, 0);
    chk("rst_dirs", {lft_dir, rght_dir}, 0);
    chk("rst_prd_strt", prd_strt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_rdy", req_rdy, 1);
    rst_n = 1'b1;
    en    = 1'b1;

    // Phase: accept at cnt=5, nothing moves until cnt wraps to 0.
    for (int i = 0; i < 5; i++) step();
    send(12'h1F4, 12'h800);
    chk("accept_no_effect", lft_duty, 0);
    chk("run_busy", busy, 1);
    early = 1'b0;
    while (edge_cnt < 2047) begin
      step();
      if (pulse || lft_duty != 11'd0) early = 1'b1;
    end
    chk("phase_hold", {31'd0, early}, 0);
    step();
    chk("t1_prd_strt", prd_strt, 1);
    chk("t1_lft_duty", lft_duty, 64);
    chk("t1_lft_dir", lft_dir, 0);
    chk("t1_rght_duty", rght_duty, 64);
    chk("t1_rght_dir", rght_dir, 1);
    step();
    chk("prd_pulse_width", prd_strt, 0);

    // Ramp to +500; right saturates from -2048 in parallel.
    for (int k = 2; k <= 8; k++) tick_chk(k, (k * 64 < 500) ? k * 64 : 500, 0, k * 64, 1);
    chk("t8_busy", busy, 1);

    // Down to 128 in the same direction.
    send(12'h080, 12'h800);
    for (int k = 9; k <= 14; k++)
      tick_chk(k, (500 - 64 * (k - 8) > 128) ? 500 - 64 * (k - 8) : 128, 0, k * 64, 1);

    // Reversal to -100 through zero.
    send(12'hF9C, 12'h800);
    tick_chk(15, 64, 0, 960, 1);
    tick_chk(16, 0, 0, 1024, 1);
    tick_chk(17, 64, 1, 1088, 1);
    tick_chk(18, 100, 1, 1152, 1);

    // Left toward -1000; right reaches and holds 2047.
    send(12'hC18, 12'h800);
    for (int k = 19; k <= 33; k++) begin
      tick_chk(k, (100 + 64 * (k - 18) < 1000) ? 100 + 64 * (k - 18) : 1000, 1,
               (k * 64 < 2047) ? k * 64 : 2047, 1);
      if (k == 32) chk("t32_busy", busy, 1);
    end
    chk("t33_busy", busy, 0);

    // Brake: en low is sampled on the next tick, which already applies a brake step.
    en = 1'b0;
    tick_chk(34, 744, 1, 1791, 1);
    chk("t34_req_rdy", req_rdy, 0);
    send(12'h007, 12'h007);
    for (int k = 35; k <= 41; k++) begin
      tick_chk(k, (1000 - 256 * (k - 33) > 0) ? 1000 - 256 * (k - 33) : 0, 1,
               (2047 - 256 * (k - 33) > 0) ? 2047 - 256 * (k - 33) : 0, 1);
      if (k == 38) en = 1'b1;
      if (k == 39 || k == 40) chk($sformatf("t%0d_req_rdy", k), req_rdy, 0);
    end
    chk("idle_req_rdy", req_rdy, 1);
    chk("idle_busy", busy, 1);

    // Re-enable: targets kept (-1000/-2048), the request made during BRAKE was dropped.
    tick_chk(42, 64, 1, 64, 1);

    // Asynchronous reset mid-ramp.
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_lft_duty", lft_duty, 0);
    chk("arst_rght_duty", rght_duty, 0);
    chk("arst_dirs", {lft_dir, rght_dir}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_rdy", req_rdy, 1);
    chk("arst_prd_strt", prd_strt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
